// File: rtl/sorter_pkg.sv
// Shared helpers for the pipelined odd-even transposition sorter:
// tag width, lane slicing offsets and the compare-exchange decision.
package sorter_pkg;

  // Wide enough that any key up to 64 bits zero-extends without loss.
  localparam int CMP_W = 65;

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int key_lsb(input int lane, input int dw);
    return lane * dw;
  endfunction

  function automatic int tag_lsb(input int lane, input int iw);
    return lane * iw;
  endfunction

  // Flipping the key MSB maps two's-complement order onto unsigned order,
  // so one unsigned magnitude compare serves both signednesses.
  function automatic logic swap_needed(input logic [CMP_W-1:0] lo,
                                       input logic [CMP_W-1:0] hi,
                                       input int               dw,
                                       input logic             is_signed,
                                       input logic             desc);
    logic [CMP_W-1:0] bias;
    logic [CMP_W-1:0] a;
    logic [CMP_W-1:0] b;
    bias = is_signed ? (CMP_W'(1) << (dw - 1)) : '0;
    a    = lo ^ bias;
    b    = hi ^ bias;
    return desc ? (a < b) : (a > b);
  endfunction

endpackage

// File: rtl/sorter_pipe_cmp_swap.sv
// Combinational compare-exchange of two (key, tag) pairs; equal keys never
// swap, which keeps the whole network stable.
module sort_cmp_swap
  import sorter_pkg::*;
#(
  parameter int DW     = 8,
  parameter int IW     = 3,
  parameter int SIGNED = 0
) (
  input  logic          desc,
  input  logic [DW-1:0] lo_key,
  input  logic [IW-1:0] lo_tag,
  input  logic [DW-1:0] hi_key,
  input  logic [IW-1:0] hi_tag,
  output logic [DW-1:0] first_key,
  output logic [IW-1:0] first_tag,
  output logic [DW-1:0] second_key,
  output logic [IW-1:0] second_tag
);

  logic swap;

  assign swap = swap_needed(CMP_W'(lo_key), CMP_W'(hi_key), DW, (SIGNED != 0), desc);

  assign first_key  = swap ? hi_key : lo_key;
  assign first_tag  = swap ? hi_tag : lo_tag;
  assign second_key = swap ? lo_key : hi_key;
  assign second_tag = swap ? lo_tag : hi_tag;

endmodule

// File: rtl/sorter_pipe.sv
// N-stage odd-even transposition sorter with valid/ready streaming,
// lane-origin tags, per-vector direction and synchronous flush.
module sorter_pipe
  import sorter_pkg::*;
#(
  parameter int N      = 5,
  parameter int DW     = 8,
  parameter int SIGNED = 0,
  parameter int IW     = idx_width(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_desc,
  input  logic [DW*N-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW*N-1:0] out_data,
  output logic [IW*N-1:0] out_idx,
  output logic            out_desc
);

  if (N < 2) begin : g_bad_n
    $error("sorter_pipe: N must be at least 2");
  end

  logic [N-1:0]  stg_valid;
  logic [N-1:0]  stg_desc;
  logic [DW-1:0] stg_key [N][N];
  logic [IW-1:0] stg_tag [N][N];

  logic [N-1:0]  src_valid;
  logic [N-1:0]  src_desc;
  logic [DW-1:0] src_key [N][N];
  logic [IW-1:0] src_tag [N][N];
  logic [DW-1:0] net_key [N][N];
  logic [IW-1:0] net_tag [N][N];

  logic adv;

  // The whole pipe moves as one; only a blocked last stage can stop it.
  assign adv       = !stg_valid[N-1] || out_ready;
  assign in_ready  = adv;
  assign src_valid = {stg_valid[N-2:0], in_valid};
  assign src_desc  = {stg_desc[N-2:0], in_desc};

  for (genvar k = 0; k < N; k++) begin : g_lane_io
    assign src_key[0][k] = in_data[key_lsb(k, DW) +: DW];
    assign src_tag[0][k] = IW'(k);
    assign out_data[key_lsb(k, DW) +: DW] = stg_key[N-1][k];
    assign out_idx[tag_lsb(k, IW) +: IW]  = stg_tag[N-1][k];
  end

  for (genvar s = 1; s < N; s++) begin : g_chain
    for (genvar k = 0; k < N; k++) begin : g_lane
      assign src_key[s][k] = stg_key[s-1][k];
      assign src_tag[s][k] = stg_tag[s-1][k];
    end
  end

  // Even stages pair (0,1),(2,3)...; odd stages pair (1,2),(3,4)...
  for (genvar s = 0; s < N; s++) begin : g_stage
    for (genvar k = 0; k < N; k++) begin : g_lane
      if (((k % 2) == (s % 2)) && (k + 1 < N)) begin : g_pair
        sort_cmp_swap #(
          .DW     (DW),
          .IW     (IW),
          .SIGNED (SIGNED)
        ) u_cs (
          .desc       (src_desc[s]),
          .lo_key     (src_key[s][k]),
          .lo_tag     (src_tag[s][k]),
          .hi_key     (src_key[s][k+1]),
          .hi_tag     (src_tag[s][k+1]),
          .first_key  (net_key[s][k]),
          .first_tag  (net_tag[s][k]),
          .second_key (net_key[s][k+1]),
          .second_tag (net_tag[s][k+1])
        );
      end else if (!(((k % 2) != (s % 2)) && (k > 0))) begin : g_pass
        assign net_key[s][k] = src_key[s][k];
        assign net_tag[s][k] = src_tag[s][k];
      end
    end
  end

  // Stage registers; flush drops valids (and the offered input) but keeps data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_valid <= '0;
      stg_desc  <= '0;
      for (int s = 0; s < N; s++) begin
        for (int k = 0; k < N; k++) begin
          stg_key[s][k] <= '0;
          stg_tag[s][k] <= '0;
        end
      end
    end else if (adv) begin
      stg_valid <= flush ? '0 : src_valid;
      stg_desc  <= src_desc;
      for (int s = 0; s < N; s++) begin
        for (int k = 0; k < N; k++) begin
          stg_key[s][k] <= net_key[s][k];
          stg_tag[s][k] <= net_tag[s][k];
        end
      end
    end else if (flush) begin
      stg_valid <= '0;
    end
  end

  assign out_valid = stg_valid[N-1];
  assign out_desc  = stg_desc[N-1];

endmodule

// File: tb/tb_sorter_pipe.sv
// Randomised bench for sorter_pipe: an unsigned and a signed instance share
// stimulus and are checked against an insertion-sort reference model.
module tb_sorter_pipe;
  localparam int N  = 5;
  localparam int DW = 8;
  localparam int IW = 3;

  logic clk = 1'b0;
  logic rst, flush, in_valid, in_desc, out_ready;
  logic [DW*N-1:0] in_data;
  logic in_ready, out_valid, out_desc;
  logic [DW*N-1:0] out_data;
  logic [IW*N-1:0] out_idx;
  logic s_in_ready, s_out_valid, s_out_desc;
  logic [DW*N-1:0] s_out_data;
  logic [IW*N-1:0] s_out_idx;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [DW*N-1:0] ud;
    logic [IW*N-1:0] ui;
    logic [DW*N-1:0] sd;
    logic [IW*N-1:0] si;
    logic            desc;
  } exp_t;

  exp_t expq[$];

  always #5 clk = ~clk;

  sorter_pipe #(.N(N), .DW(DW), .SIGNED(0)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_desc(in_desc), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_desc(out_desc));

  sorter_pipe #(.N(N), .DW(DW), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_desc(in_desc), .in_data(in_data), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_data(s_out_data), .out_idx(s_out_idx), .out_desc(s_out_desc));

  // Stable insertion sort of the lanes, once unsigned and once signed.
  function automatic exp_t model(input logic [DW*N-1:0] data, input logic desc);
    exp_t e;
    int key[N];
    int idx[N];
    int t;
    logic [DW-1:0] b;
    e = '0;
    e.desc = desc;
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < N; k++) begin
        b = data[DW*k +: DW];
        key[k] = (pass == 1) ? int'($signed(b)) : int'(b);
        idx[k] = k;
      end
      for (int i = 1; i < N; i++) begin
        for (int j = i; j > 0; j--) begin
          if (desc ? (key[j] > key[j-1]) : (key[j] < key[j-1])) begin
            t = key[j]; key[j] = key[j-1]; key[j-1] = t;
            t = idx[j]; idx[j] = idx[j-1]; idx[j-1] = t;
          end else begin
            break;
          end
        end
      end
      for (int k = 0; k < N; k++) begin
        if (pass == 0) begin
          e.ud[DW*k +: DW] = key[k][DW-1:0];
          e.ui[IW*k +: IW] = idx[k][IW-1:0];
        end else begin
          e.sd[DW*k +: DW] = key[k][DW-1:0];
          e.si[IW*k +: IW] = idx[k][IW-1:0];
        end
      end
    end
    return e;
  endfunction

  function automatic logic [DW*N-1:0] rand_vec();
    return (DW*N)'({$urandom(), $urandom()});
  endfunction

  // Offers one vector to an empty pipe and captures the first output of both DUTs.
  task automatic send_one(input logic [DW*N-1:0] data, input logic desc,
                          output exp_t got, output int lat);
    got = '0;
    lat = -1;
    @(negedge clk);
    in_valid = 1'b1; in_data = data; in_desc = desc; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    for (int c = 1; c <= 4*N; c++) begin
      if (out_valid) begin
        lat = c;
        got.ud = out_data; got.ui = out_idx; got.desc = out_desc;
        got.sd = s_out_data; got.si = s_out_idx;
        break;
      end
      @(negedge clk);
      #1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_desc = 1'b0;
    in_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL reset_out_data got %h want 0", out_data); end
    n_cmp++; if (out_idx !== '0) begin n_bad++; $display("FAIL reset_out_idx got %h want 0", out_idx); end
    n_cmp++; if (out_desc !== 1'b0) begin n_bad++; $display("FAIL reset_out_desc got %b want 0", out_desc); end
    rst = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_ascending();
    exp_t got; int lat;
    send_one({8'd5, 8'd1, 8'd4, 8'd1, 8'd3}, 1'b0, got, lat);
    n_cmp++; if (lat !== N) begin n_bad++; $display("FAIL asc_latency got %0d want %0d", lat, N); end
    n_cmp++; if (got.ud !== {8'd5, 8'd4, 8'd3, 8'd1, 8'd1}) begin n_bad++; $display("FAIL asc_data got %h want 0504030101", got.ud); end
    n_cmp++; if (got.ui !== {3'd4, 3'd2, 3'd0, 3'd3, 3'd1}) begin n_bad++; $display("FAIL asc_idx got %h want %h", got.ui, {3'd4, 3'd2, 3'd0, 3'd3, 3'd1}); end
    n_cmp++; if (got.desc !== 1'b0) begin n_bad++; $display("FAIL asc_desc got %b want 0", got.desc); end
  endtask

  task automatic test_descending();
    exp_t got; int lat;
    send_one({8'd5, 8'd1, 8'd4, 8'd1, 8'd3}, 1'b1, got, lat);
    n_cmp++; if (lat !== N) begin n_bad++; $display("FAIL desc_latency got %0d want %0d", lat, N); end
    n_cmp++; if (got.ud !== {8'd1, 8'd1, 8'd3, 8'd4, 8'd5}) begin n_bad++; $display("FAIL desc_data got %h want 0101030405", got.ud); end
    n_cmp++; if (got.ui !== {3'd3, 3'd1, 3'd0, 3'd2, 3'd4}) begin n_bad++; $display("FAIL desc_idx got %h want %h", got.ui, {3'd3, 3'd1, 3'd0, 3'd2, 3'd4}); end
    n_cmp++; if (got.desc !== 1'b1) begin n_bad++; $display("FAIL desc_flag got %b want 1", got.desc); end
  endtask

  task automatic test_signed();
    exp_t got; exp_t e; int lat; logic [DW*N-1:0] v;
    send_one({8'h01, 8'hFF, 8'h00, 8'h7F, 8'h80}, 1'b0, got, lat);
    n_cmp++; if (got.sd !== {8'h7F, 8'h01, 8'h00, 8'hFF, 8'h80}) begin n_bad++; $display("FAIL signed_data got %h want 7f0100ff80", got.sd); end
    n_cmp++; if (got.si !== {3'd1, 3'd4, 3'd2, 3'd3, 3'd0}) begin n_bad++; $display("FAIL signed_idx got %h want %h", got.si, {3'd1, 3'd4, 3'd2, 3'd3, 3'd0}); end
    n_cmp++; if (got.ud !== {8'hFF, 8'h80, 8'h7F, 8'h01, 8'h00}) begin n_bad++; $display("FAIL unsigned_mix_data got %h want ff807f0100", got.ud); end
    v = rand_vec();
    e = model(v, 1'b1);
    send_one(v, 1'b1, got, lat);
    n_cmp++; if (got.sd !== e.sd || got.si !== e.si) begin n_bad++; $display("FAIL signed_rand_desc got %h/%h want %h/%h", got.sd, got.si, e.sd, e.si); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int sent = 0, recv = 0, first_acc = -1, first_out = -1, last_out = -1;
    expq.delete();
    for (int c = 0; c < 8*N && recv < 5; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (sent < 5) begin
        in_valid = 1'b1; in_data = rand_vec(); in_desc = sent[0];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid && in_ready) begin
        expq.push_back(model(in_data, in_desc));
        if (first_acc < 0) first_acc = c;
        sent++;
      end
      if (out_valid && out_ready) begin
        if (first_out < 0) first_out = c;
        last_out = c;
        recv++;
        n_cmp++;
        if (expq.size() == 0) begin
          n_bad++; $display("FAIL b2b_extra got unexpected vector %h", out_data);
        end else begin
          e = expq.pop_front();
          if (out_data !== e.ud || out_idx !== e.ui || out_desc !== e.desc ||
              s_out_data !== e.sd || s_out_idx !== e.si) begin
            n_bad++;
            $display("FAIL b2b_vec got %h/%h/%b signed %h/%h want %h/%h/%b signed %h/%h",
                     out_data, out_idx, out_desc, s_out_data, s_out_idx, e.ud, e.ui, e.desc, e.sd, e.si);
          end
        end
      end
    end
    n_cmp++; if (recv !== 5) begin n_bad++; $display("FAIL b2b_count got %0d want 5", recv); end
    n_cmp++; if (first_out - first_acc !== N) begin n_bad++; $display("FAIL b2b_latency got %0d want %0d", first_out - first_acc, N); end
    n_cmp++; if (last_out - first_out !== 4) begin n_bad++; $display("FAIL b2b_gapless got %0d want 4", last_out - first_out); end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int sent = 0, recv = 0;
    logic [DW*N-1:0] held_d;
    logic [IW*N-1:0] held_i;
    expq.delete();
    for (int c = 0; c < 20*N && (sent < 8 || recv < 8); c++) begin
      @(negedge clk);
      in_valid = (sent < 8);
      in_data  = rand_vec();
      in_desc  = 1'($urandom_range(0, 1));
      if (c >= N + 1 && c < N + 4) out_ready = 1'b0;
      else if (c < N + 4) out_ready = 1'b1;
      else out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (c == N + 1) begin
        held_d = out_data; held_i = out_idx;
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_full got out_valid %b want 1", out_valid); end
      end
      if (c >= N + 1 && c < N + 4) begin
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready cycle %0d got %b want 0", c, in_ready); end
      end
      if (c >= N + 2 && c <= N + 4) begin
        n_cmp++; if (out_data !== held_d || out_idx !== held_i) begin
          n_bad++; $display("FAIL bp_hold cycle %0d got %h/%h want %h/%h", c, out_data, out_idx, held_d, held_i);
        end
      end
      if (in_valid && in_ready) begin
        expq.push_back(model(in_data, in_desc));
        sent++;
      end
      if (out_valid && out_ready) begin
        recv++;
        n_cmp++;
        if (expq.size() == 0) begin
          n_bad++; $display("FAIL bp_extra got unexpected vector %h", out_data);
        end else begin
          e = expq.pop_front();
          if (out_data !== e.ud || out_idx !== e.ui || out_desc !== e.desc || s_out_data !== e.sd) begin
            n_bad++; $display("FAIL bp_vec got %h/%h/%b want %h/%h/%b", out_data, out_idx, out_desc, e.ud, e.ui, e.desc);
          end
        end
      end
    end
    n_cmp++; if (sent !== 8 || recv !== 8) begin n_bad++; $display("FAIL bp_count got sent %0d recv %0d want 8/8", sent, recv); end
    n_cmp++; if (expq.size() !== 0) begin n_bad++; $display("FAIL bp_leftover got %0d want 0", expq.size()); end
  endtask

  // Streams three vectors and waits until the oldest reaches the output.
  task automatic fill_three(output logic seen);
    seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = rand_vec(); in_desc = 1'b0; out_ready = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    for (int c = 0; c < 4*N; c++) begin
      if (out_valid) begin seen = 1'b1; break; end
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_rst_midstream();
    logic seen; int stale = 0;
    fill_three(seen);
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL rst_fill got out_valid %b want 1", seen); end
    rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_async got out_valid %b want 0", out_valid); end
    n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL rst_data got %h want 0", out_data); end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3*N; c++) begin
      @(negedge clk);
      #1;
      if (out_valid) stale++;
    end
    n_cmp++; if (stale !== 0) begin n_bad++; $display("FAIL rst_stale got %0d want 0", stale); end
  endtask

  task automatic test_flush();
    logic seen; int stale = 0; exp_t got; exp_t e; int lat; logic [DW*N-1:0] v;
    fill_three(seen);
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL flush_fill got out_valid %b want 1", seen); end
    flush = 1'b1; in_valid = 1'b1; in_data = rand_vec();
    #1;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL flush_sync got out_valid %b want 1", out_valid); end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_clear got out_valid %b want 0", out_valid); end
    for (int c = 0; c < 3*N; c++) begin
      @(negedge clk);
      #1;
      if (out_valid) stale++;
    end
    n_cmp++; if (stale !== 0) begin n_bad++; $display("FAIL flush_stale got %0d want 0", stale); end
    v = rand_vec();
    e = model(v, 1'b0);
    send_one(v, 1'b0, got, lat);
    n_cmp++; if (lat !== N || got.ud !== e.ud || got.ui !== e.ui) begin
      n_bad++; $display("FAIL flush_recover got %h/%h lat %0d want %h/%h lat %0d", got.ud, got.ui, lat, e.ud, e.ui, N);
    end
  endtask

  initial begin
    test_reset();
    test_ascending();
    test_descending();
    test_signed();
    test_back_to_back();
    test_backpressure();
    test_rst_midstream();
    test_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sorter_pipe.md
# sorter_pipe

Pipelined, parametrised N-lane sorter. Accepts one vector of N unsigned or signed DW-bit keys per cycle over a valid/ready handshake and emits it fully sorted N cycles later, with the original lane index of every output element. Sort direction is selectable per vector. It is the clocked, streaming successor to the combinational comparator-chain sorter, for use between stream stages that need ranked data (median/top-k filters, priority pickers).

## Interface
- `N`, 5: number of lanes; legal range is N ≥ 2.
- `DW`, 8: key width in bits.
- `SIGNED`, 0: 1 means keys compare as two's complement; 0 means unsigned.
- `IW`, $clog2(N): index tag width. Derived; not overridden.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `flush` in 1: synchronous; drops every in-flight vector.
- `in_valid` in 1: input vector present.
- `in_ready` out 1: sorter accepts the vector this cycle.
- `in_desc` in 1: 0 = ascending, 1 = descending. Sampled with the data.
- `in_data` in DW*N: lane k occupies bits [DW*k +: DW].
- `out_valid` out 1: sorted vector present.
- `out_ready` in 1: downstream accepts the vector.
- `out_data` out DW*N: sorted keys. Lane 0 is the first in sort order.
- `out_idx` out IW*N: `out_idx` lane k holds the input lane that `out_data` lane k came from.
- `out_desc` out 1: the direction flag that travelled with the vector.

## Operation
- The sorter is an odd-even transposition network of N register stages, s = 0..N-1.
- Stage s with s even compare-swaps lane pairs (0,1),(2,3),… Stage s with s odd compare-swaps lane pairs (1,2),(3,4),… An unpaired edge lane passes through.
- Each stage register holds a valid bit, the desc bit, N keys and N index tags.
- On entry, the tag for lane k is k.
- Swap rule:
  - Ascending: swap when key[lo] > key[hi], strictly.
  - Descending: swap when key[lo] < key[hi], strictly.
  - Equal keys never swap, so the sort is stable: among ties, the lower input lane comes out first.
- Comparison is DW-bit. With SIGNED=1 it is a signed compare. There is no widening and no saturation.
- Keys and tags move together on every swap.
- Global advance: `adv = !v[N-1] || out_ready`.
  - When adv=1, all stages shift by one.
  - `in_ready = adv`.
  - Stage 0 loads `in_valid && in_ready`.
- Bubbles are not compressed. An empty slot moves forward like data.
- `out_*` are driven directly from stage N-1 registers. There is no combinational path from `in_data` to `out_data`.
- `flush` clears every valid bit at the next edge, and the input offered in that same cycle is dropped. Data registers may keep stale values.

## Timing
- Reset values:
  - all valid bits 0, so `out_valid` = 0.
  - `out_data` = 0, `out_idx` = 0, `out_desc` = 0.
  - `in_ready` = 1 once reset is released, because the last stage is empty.
- Latency: a vector accepted at edge t appears with `out_valid` = 1 after edge t+N-1, provided there is no stall. That is N register stages.
- Throughput: one vector per cycle while `out_ready` = 1.
- Stall: with `out_valid` = 1 and `out_ready` = 0:
  - every stage holds;
  - `in_ready` = 0;
  - `out_*` stay stable until the handshake completes.
- When `out_valid` = 0, `in_ready` = 1 regardless of `out_ready`.
- Simultaneous output handshake and input acceptance in one cycle is legal and loses nothing.
- `rst` asserted mid-stream: valid bits clear asynchronously and `out_valid` drops without waiting for a clock edge. All in-flight data is discarded.
- If `flush` and `rst` are both asserted, `rst` dominates.

## Structure
- Shared package `sorter_pkg`:
  - index-width helper function (clog2, with a minimum of 1);
  - lane slicing helpers for key and tag;
  - a compare function parametrised on SIGNED and direction.
- Sub-module `sort_cmp_swap`: combinational compare-exchange of two (key, tag) pairs with inputs desc and SIGNED. It is instantiated floor(N/2) or floor((N-1)/2) times per stage by generate loops.
- Top level `sorter_pipe` holds the stage registers, the valid/advance logic and flush.

## Test plan
- Ascending: N=5, DW=8, in_data lanes 0..4 = 3,1,4,1,5, desc=0 → after 5 cycles out_data = 1,1,3,4,5 and out_idx = 1,3,0,2,4.
- Descending: same vector, desc=1 → out_data = 5,4,3,1,1 and out_idx = 4,2,0,1,3; out_desc = 1.
- Streaming and signed:
  - Five random vectors back-to-back with out_ready=1 and alternating desc → five consecutive out_valid cycles, in order, each matching a reference model.
  - SIGNED=1: 0x80,0x7F,0x00,0xFF,0x01 → 0x80,0xFF,0x00,0x01,0x7F.
- Backpressure: fill the pipe, then hold out_ready=0 for 3 cycles → in_ready=0 and out_data/out_idx constant; after release, every vector is delivered exactly once, in order.
- rst and flush mid-stream:
  - rst pulse with 3 vectors in flight → out_valid=0 before the next edge, and no stale vector afterwards.
  - Repeat with flush → same result one edge later; a vector offered in the flush cycle is dropped.
